ula_seq_param: RTL
==================

Name: ula_seq_param

Overview:
Parametrised, registered successor to the team's 4-bit combinational ALU. Supports logic ops, add/sub with flags, an accumulator, and a multi-cycle shift-add multiplier. Uses a start/busy/done handshake. Sits between the operand registers and the result bus of the SD1 datapath exercises.

Parameters:
WIDTH, 4, operand/result width in bits (>=2)
CNT_W, $clog2(WIDTH)+1, width of the internal multiply step counter (derived; do not override)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  synchronous reset, active-low
start  input  1  request; sampled only when busy=0
seletor  input  3  operation code, captured with start
A  input  WIDTH  operand A, captured with start
B  input  WIDTH  operand B, captured with start
Cin  input  1  carry-in for ADD, captured with start
clr_acc  input  1  synchronous accumulator clear
resultado  output  WIDTH  result register (low half for MUL)
resultado_hi  output  WIDTH  high half of MUL product; 0 for other ops
Cout  output  1  carry flag
Zout  output  1  zero flag (resultado==0, and for MUL also resultado_hi==0)
Nout  output  1  resultado[WIDTH-1]
Vout  output  1  signed overflow flag
busy  output  1  high while a MUL is in progress
done  output  1  one-cycle pulse: resultado/flags valid

Behaviour:
- Reset (rst_n=0 at clk edge): resultado, resultado_hi, acc, all flags, busy, done = 0; FSM -> IDLE. Reset overrides everything, including an in-flight MUL (discarded, no done).
- Clock and reset: one clock; reset is synchronous and active-low.
- FSM states: IDLE, MUL_RUN, DONE_PULSE.
- IDLE + start=1: capture A, B, Cin, seletor.
  - Single-cycle ops: the result and flags are registered at the same edge; done=1 in the next cycle (latency 1).
  - MUL: go to MUL_RUN, busy=1.
- start while busy=1: ignored; operands are not recaptured.
- Opcodes:
  - 000: A&B
  - 001: A|B
  - 010: ~A
  - 011: ~(A&B)
  - 100: A+B+Cin
  - 101: A-B
  - 110: MUL
  - 111: ACC, where acc <= acc+A and resultado <= new acc
- Logic ops: Cout=0, Vout=0.
- ADD: computed at WIDTH+1 bits. Cout = bit WIDTH. Vout = (A[msb]==B[msb]) && (sum[msb]!=A[msb]).
- SUB: computed as A+~B+1. Cout=1 means no borrow (A>=B unsigned). Vout = (A[msb]!=B[msb]) && (diff[msb]!=A[msb]).
- ACC: wraps modulo 2^WIDTH. Cout/Vout are as for ADD of acc+A.
- Accumulator clear:
  - clr_acc=1 clears acc at that edge.
  - If clr_acc and an ACC start coincide, clear wins first and the result is 0+A.
  - clr_acc does not affect other ops.
- MUL (unsigned shift-add):
  - Exactly WIDTH cycles in MUL_RUN, one bit of B per cycle, LSB first.
  - Then DONE_PULSE: {resultado_hi,resultado} = A*B, busy=0, done=1.
  - Total: start edge to done high = WIDTH+1 cycles.
  - Cout=0; Vout = (resultado_hi != 0).
- done: high for exactly one cycle per accepted op.
  - Outputs hold their values until the next accepted op completes.
  - resultado_hi is cleared by any non-MUL op.
- Back-to-back: start may be asserted in the same cycle as done=1. It is accepted because busy=0.

Optional Feature:
Macro ULA_MUL_EN.
- Defined: MUL is implemented as above.
- Undefined: no multiplier logic and no MUL_RUN state. Opcode 110 completes in 1 cycle with resultado=0, resultado_hi=0, Zout=1, Cout=Vout=0; busy stays 0.

Test Plan:
- Reset: drive rst_n=0 mid-MUL (A=7,B=9), release -> all outputs 0, busy=0, no done pulse; then ADD 3+4 -> done after 1 cycle, resultado=7.
- ADD/SUB flags (WIDTH=4): 7+1, Cin=0 -> resultado=8, Vout=1, Nout=1, Cout=0. 15+1 -> 0, Cout=1, Zout=1. 3-5 -> 14 (0xE), Cout=0, Nout=1.
- Logic ops: A=0xA, B=0x6 -> AND=0x2, OR=0xE, NOT A=0x5, NAND=0xD; Cout=Vout=0 for each.
- MUL (ULA_MUL_EN on, WIDTH=4): 13*11 -> busy for 4 cycles, done at cycle 5, resultado_hi=0x8, resultado=0xF, Vout=1. A start pulse during busy is ignored.
- Accumulator: clr_acc, then ACC A=9 twice -> 9, then 2 (wrap) with Cout=1. clr_acc coinciding with ACC A=3 -> 3.
- MUL with ULA_MUL_EN undefined: op 110 with A=5, B=5 -> done after 1 cycle, resultado=0, Zout=1, busy never asserted.

Source files
------------

// File: rtl/ula_seq_param_if.sv
// Operand/result bundle for ula_seq_param: start/busy/done handshake plus ALU operands and flags.
interface ula_seq_param_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [2:0]       seletor;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             clr_acc;
    logic [WIDTH-1:0] resultado;
    logic [WIDTH-1:0] resultado_hi;
    logic             Cout;
    logic             Zout;
    logic             Nout;
    logic             Vout;
    logic             busy;
    logic             done;

    modport master (
        output start, seletor, A, B, Cin, clr_acc,
        input  resultado, resultado_hi, Cout, Zout, Nout, Vout, busy, done
    );

    modport slave (
        input  start, seletor, A, B, Cin, clr_acc,
        output resultado, resultado_hi, Cout, Zout, Nout, Vout, busy, done
    );
endinterface

// File: rtl/ula_seq_param.sv
// Registered ALU with accumulator and start/busy/done handshake.
// Define ULA_MUL_EN to build the shift-add multiplier; otherwise opcode 110 returns zero in one cycle.
module ula_seq_param #(
    parameter int  WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input logic            clk,
    input logic            rst_n,
    ula_seq_param_if.slave bus
);
    localparam int         MSB    = WIDTH - 1;
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_ACC = 3'b111;

    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_acc;
    logic             r_c;
    logic             r_z;
    logic             r_v;
    logic             r_done;

    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_acc_base;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_acc_sum;
    logic             w_c;
    logic             w_v;
    logic             w_accept;
    logic             w_single;

`ifdef ULA_MUL_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL_RUN, S_DONE_PULSE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_mhi;
    logic [WIDTH-1:0]   r_mlo;
    logic [WIDTH:0]     w_step;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_mul_last;

    // DONE_PULSE is not busy, so a new op can start in the same cycle done is shown.
    assign w_accept   = bus.start && (r_state != S_MUL_RUN);
    assign w_single   = w_accept && (bus.seletor != OP_MUL);
    assign w_mul_last = (r_state == S_MUL_RUN) && (r_cnt == CNT_W'(1));
    assign w_step     = {1'b0, r_mhi} + (r_mlo[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
    assign w_prod     = {w_step, r_mlo[WIDTH-1:1]};
    assign bus.busy   = (r_state == S_MUL_RUN);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = S_IDLE;
        case (r_state)
            S_MUL_RUN: w_state_nxt = w_mul_last ? S_DONE_PULSE : S_MUL_RUN;
            default:   if (w_accept && bus.seletor == OP_MUL) w_state_nxt = S_MUL_RUN;
        endcase
    end

    // {r_mhi, r_mlo} starts as {0, B}; each step adds A on B's LSB and shifts right.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_a   <= '0;
            r_mhi <= '0;
            r_mlo <= '0;
        end else if (w_accept && bus.seletor == OP_MUL) begin
            r_cnt <= CNT_W'(WIDTH);
            r_a   <= bus.A;
            r_mhi <= '0;
            r_mlo <= bus.B;
        end else if (r_state == S_MUL_RUN) begin
            r_cnt          <= r_cnt - CNT_W'(1);
            {r_mhi, r_mlo} <= w_prod;
        end
    end
`else
    assign w_accept = bus.start;
    assign w_single = bus.start;
    assign bus.busy = 1'b0;
`endif

    always_comb begin
        w_acc_base = bus.clr_acc ? '0 : r_acc;
        w_sum      = {1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, bus.Cin};
        w_diff     = {1'b0, bus.A} + {1'b0, ~bus.B} + {{WIDTH{1'b0}}, 1'b1};
        w_acc_sum  = {1'b0, w_acc_base} + {1'b0, bus.A};
        w_res      = '0;
        w_c        = 1'b0;
        w_v        = 1'b0;
        case (bus.seletor)
            OP_AND:  w_res = bus.A & bus.B;
            OP_OR:   w_res = bus.A | bus.B;
            OP_NOT:  w_res = ~bus.A;
            OP_NAND: w_res = ~(bus.A & bus.B);
            OP_ADD: begin
                w_res = w_sum[MSB:0];
                w_c   = w_sum[WIDTH];
                w_v   = (bus.A[MSB] == bus.B[MSB]) && (w_sum[MSB] != bus.A[MSB]);
            end
            OP_SUB: begin
                w_res = w_diff[MSB:0];
                w_c   = w_diff[WIDTH];
                w_v   = (bus.A[MSB] != bus.B[MSB]) && (w_diff[MSB] != bus.A[MSB]);
            end
            OP_ACC: begin
                w_res = w_acc_sum[MSB:0];
                w_c   = w_acc_sum[WIDTH];
                w_v   = (w_acc_base[MSB] == bus.A[MSB]) && (w_acc_sum[MSB] != bus.A[MSB]);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_res  <= '0;
            r_hi   <= '0;
            r_acc  <= '0;
            r_c    <= 1'b0;
            r_z    <= 1'b0;
            r_v    <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.clr_acc) r_acc <= '0;
            if (w_accept && bus.seletor == OP_ACC) r_acc <= w_acc_sum[MSB:0];
            if (w_single) begin
                r_res  <= w_res;
                r_hi   <= '0;
                r_c    <= w_c;
                r_v    <= w_v;
                r_z    <= (w_res == '0);
                r_done <= 1'b1;
            end
`ifdef ULA_MUL_EN
            if (w_mul_last) begin
                r_res  <= w_prod[MSB:0];
                r_hi   <= w_prod[2*WIDTH-1:WIDTH];
                r_c    <= 1'b0;
                r_v    <= |w_prod[2*WIDTH-1:WIDTH];
                r_z    <= (w_prod == '0);
                r_done <= 1'b1;
            end
`endif
        end
    end

    assign bus.resultado    = r_res;
    assign bus.resultado_hi = r_hi;
    assign bus.Cout         = r_c;
    assign bus.Zout         = r_z;
    assign bus.Nout         = r_res[MSB];
    assign bus.Vout         = r_v;
    assign bus.done         = r_done;
endmodule
